upg_load_ctrl: RTL and testbench
================================

// Module: upg_load_ctrl
// PURPOSE
//  Sequences the UART-programming / CPU-run modes and routes UART programmer writes to imem or dmem.
//  Sits between the uart block and the Ifetc32/dmemory32 write ports.
//  In LOAD it holds the CPU in reset and steers each upg word by address bit 14.
//  It then releases the CPU after a flush delay.
// PARAMETERS
//  DEBOUNCE   20'd100000  cycles start_pg must stay high to enter programming
//  FLUSH_CYC  8'd16       cycles CPU reset is held after upg_done_i before RUN
//  TIMEOUT    24'hFFFFFF  idle cycles in LOAD (no write, no done) before abort
// PORTS
//  clock       in   1   system clock (23 MHz cpuclk)
//  reset       in   1   synchronous, active-high
//  start_pg    in   1   programming request button, already synchronised
//  upg_wen_i   in   1   uart word write strobe, 1 cycle
//  upg_adr_i   in   15  [14]=0 imem, 1 dmem; [13:0] word address
//  upg_dat_i   in   32  uart word data
//  upg_done_i  in   1   uart transfer complete (level)
//  upg_rst_o   out  1   uart reset, 1 = uart held idle
//  cpu_rst_o   out  1   CPU reset to Ifetc32/decode32/dmemory32
//  imem_wen_o  out  1   instruction memory write pulse
//  dmem_wen_o  out  1   data memory write pulse
//  mem_adr_o   out  14  registered word address
//  mem_dat_o   out  32  registered write data
//  imem_cnt_o  out  16  words written to imem this session, saturating
//  dmem_cnt_o  out  16  words written to dmem this session, saturating
//  state_o     out  2   00 RUN, 01 ARM, 10 LOAD, 11 FLUSH
//  err_o       out  1   sticky: last session aborted by TIMEOUT
// BEHAVIOUR
//  Reset values: state RUN, upg_rst_o=1, cpu_rst_o=1, wen outs 0, adr/dat 0, cnts 0, err_o 0.
//  After reset: cpu_rst_o=1 for exactly the reset cycles plus 1, then 0 in RUN.
//  All outputs are registered.
//  RUN: upg_rst_o=1, cpu_rst_o=0.
//   - Debounce counter increments while start_pg=1 and clears when start_pg=0.
//   - Reaching DEBOUNCE-1 moves to ARM; the counter clears.
//   - upg_wen_i and upg_done_i are ignored.
//  ARM: upg_rst_o=0, cpu_rst_o=1; both cnts clear and err_o clears on entry.
//   - First upg_wen_i goes to LOAD; that write is forwarded.
//   - upg_done_i with no write goes to FLUSH (empty image).
//  LOAD: upg_rst_o=0, cpu_rst_o=1.
//   - Each upg_wen_i produces 1-cycle imem_wen_o/dmem_wen_o on the next cycle (latency 1).
//   - mem_adr_o/mem_dat_o are valid in that same cycle.
//   - The selected count increments, saturating at 16'hFFFF.
//   - upg_done_i goes to FLUSH; if wen_i and done_i occur together, the write is forwarded first.
//   - Idle counter counts cycles without wen_i; it resets on each write.
//   - When it reaches TIMEOUT: set err_o, go to FLUSH.
//  FLUSH: upg_rst_o=1, cpu_rst_o=1, no writes forwarded.
//   - After FLUSH_CYC cycles, go to RUN; cpu_rst_o drops on entry to RUN.
//  start_pg is ignored outside RUN. A held button re-arms only after release and a new debounce.
//  Only one wen output is high in any cycle. wen outputs are never high outside the cycle after a LOAD/ARM write.
//  reset in any state forces the reset values next cycle; a partial image stays in memory and counts clear.
// TESTING
//  1. Reset 3 cycles, start_pg=0 -> cpu_rst_o 1 then 0 one cycle after reset; state_o=00, upg_rst_o=1.
//  2. start_pg=1 for DEBOUNCE-2 cycles, then 0 -> stays RUN. Hold DEBOUNCE cycles -> ARM, cpu_rst_o=1, upg_rst_o=0.
//  3. In ARM, write adr=15'h0004 dat=32'h2408_0001, then adr=15'h4010 dat=32'hDEAD_BEEF:
//     - imem_wen_o pulse with adr 14'h0004, then dmem_wen_o pulse with adr 14'h0010.
//     - imem_cnt_o=1, dmem_cnt_o=1.
//  4. wen_i and done_i in same cycle in LOAD -> write forwarded, FLUSH.
//     FLUSH_CYC=16 cycles later -> RUN, cpu_rst_o=0.
//  5. LOAD, no activity for TIMEOUT (bench sets 100) -> err_o=1, FLUSH, then RUN. Next ARM entry clears err_o.
//  6. reset mid-LOAD after 5 writes -> next cycle RUN, cnts 0, wen 0.
//     A wen_i while in RUN -> no wen output.

Source files
------------

// File: rtl/upg_load_ctrl.sv
// Mode sequencer for UART programming: RUN -> ARM -> LOAD -> FLUSH -> RUN.
// Holds the CPU in reset while loading and steers each UART word to imem or dmem by address bit 14.
module upg_load_ctrl #(
    parameter logic [19:0] DEBOUNCE  = 20'd100000,
    parameter logic [7:0]  FLUSH_CYC = 8'd16,
    parameter logic [23:0] TIMEOUT   = 24'hFFFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_pg,
    input  logic        upg_wen_i,
    input  logic [14:0] upg_adr_i,
    input  logic [31:0] upg_dat_i,
    input  logic        upg_done_i,
    output logic        upg_rst_o,
    output logic        cpu_rst_o,
    output logic        imem_wen_o,
    output logic        dmem_wen_o,
    output logic [13:0] mem_adr_o,
    output logic [31:0] mem_dat_o,
    output logic [15:0] imem_cnt_o,
    output logic [15:0] dmem_cnt_o,
    output logic [1:0]  state_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        ARM   = 2'b01,
        LOAD  = 2'b10,
        FLUSH = 2'b11
    } state_t;

    state_t      state, state_nxt;
    logic [19:0] deb_cnt;
    logic [23:0] idle_cnt;
    logic [7:0]  flush_cnt;
    logic        need_release;
    logic        post_reset;
    logic        fwd;
    logic        timeout_hit;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt   = state;
        fwd         = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            RUN: begin
                if (start_pg && !need_release && deb_cnt == DEBOUNCE - 20'd1)
                    state_nxt = ARM;
            end
            ARM: begin
                fwd = upg_wen_i;
                if (upg_done_i)
                    state_nxt = FLUSH;
                else if (upg_wen_i)
                    state_nxt = LOAD;
            end
            LOAD: begin
                fwd = upg_wen_i;
                if (upg_done_i) begin
                    state_nxt = FLUSH;
                end else if (!upg_wen_i && idle_cnt == TIMEOUT - 24'd1) begin
                    timeout_hit = 1'b1;
                    state_nxt   = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == FLUSH_CYC - 8'd1)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            upg_rst_o    <= 1'b1;
            cpu_rst_o    <= 1'b1;
            imem_wen_o   <= 1'b0;
            dmem_wen_o   <= 1'b0;
            mem_adr_o    <= '0;
            mem_dat_o    <= '0;
            imem_cnt_o   <= '0;
            dmem_cnt_o   <= '0;
            err_o        <= 1'b0;
            deb_cnt      <= '0;
            idle_cnt     <= '0;
            flush_cnt    <= '0;
            need_release <= 1'b0;
            post_reset   <= 1'b1;
        end else begin
            state      <= state_nxt;
            post_reset <= 1'b0;
            // Outputs follow the next state so they change on the same edge as state_o.
            cpu_rst_o  <= post_reset || (state_nxt != RUN);
            upg_rst_o  <= (state_nxt == RUN) || (state_nxt == FLUSH);

            if (state == RUN && start_pg && !need_release && state_nxt == RUN)
                deb_cnt <= deb_cnt + 20'd1;
            else
                deb_cnt <= '0;

            // A button still held when we come back to RUN must be released before it counts again.
            if (state != RUN)
                need_release <= 1'b1;
            else if (!start_pg)
                need_release <= 1'b0;

            if (state == LOAD && !upg_wen_i)
                idle_cnt <= idle_cnt + 24'd1;
            else
                idle_cnt <= '0;

            if (state == FLUSH)
                flush_cnt <= flush_cnt + 8'd1;
            else
                flush_cnt <= '0;

            imem_wen_o <= fwd && !upg_adr_i[14];
            dmem_wen_o <= fwd && upg_adr_i[14];
            if (fwd) begin
                mem_adr_o <= upg_adr_i[13:0];
                mem_dat_o <= upg_dat_i;
            end

            if (state == RUN && state_nxt == ARM) begin
                imem_cnt_o <= '0;
                dmem_cnt_o <= '0;
                err_o      <= 1'b0;
            end else if (fwd) begin
                if (!upg_adr_i[14] && imem_cnt_o != 16'hFFFF)
                    imem_cnt_o <= imem_cnt_o + 16'd1;
                if (upg_adr_i[14] && dmem_cnt_o != 16'hFFFF)
                    dmem_cnt_o <= dmem_cnt_o + 16'd1;
            end

            if (timeout_hit)
                err_o <= 1'b1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_upg_load_ctrl.sv
// Bench for upg_load_ctrl: directed mode sequencing plus random UART writes, scoreboarded
// against an expected-write queue and saturating word counters.
module tb_upg_load_ctrl;

    localparam logic [19:0] DEB  = 20'd20;
    localparam logic [7:0]  FLC  = 8'd16;
    localparam logic [23:0] TMO  = 24'd100;
    localparam logic [1:0]  S_RUN = 2'b00, S_ARM = 2'b01, S_LOAD = 2'b10, S_FLUSH = 2'b11;

    logic        clock = 1'b0;
    logic        reset, start_pg, upg_wen_i, upg_done_i;
    logic [14:0] upg_adr_i;
    logic [31:0] upg_dat_i;
    logic        upg_rst_o, cpu_rst_o, imem_wen_o, dmem_wen_o, err_o;
    logic [13:0] mem_adr_o;
    logic [31:0] mem_dat_o;
    logic [15:0] imem_cnt_o, dmem_cnt_o;
    logic [1:0]  state_o;

    upg_load_ctrl #(.DEBOUNCE(DEB), .FLUSH_CYC(FLC), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .start_pg(start_pg),
        .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
        .upg_done_i(upg_done_i), .upg_rst_o(upg_rst_o), .cpu_rst_o(cpu_rst_o),
        .imem_wen_o(imem_wen_o), .dmem_wen_o(dmem_wen_o), .mem_adr_o(mem_adr_o),
        .mem_dat_o(mem_dat_o), .imem_cnt_o(imem_cnt_o), .dmem_cnt_o(dmem_cnt_o),
        .state_o(state_o), .err_o(err_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          dmem;
        logic [13:0] adr;
        logic [31:0] dat;
        int          due;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  m_icnt, m_dcnt;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding write, one cycle after issue.
    always @(negedge clock) begin
        if (imem_wen_o || dmem_wen_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wen: imem=%0b dmem=%0b with no write pending", imem_wen_o, dmem_wen_o);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wen_select", {30'd0, imem_wen_o, dmem_wen_o}, w.dmem ? 32'd1 : 32'd2);
                check("wen_adr", {18'd0, mem_adr_o}, {18'd0, w.adr});
                check("wen_dat", mem_dat_o, w.dat);
                check("wen_latency", cyc, w.due);
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic send(input logic [14:0] adr, input logic [31:0] dat, input bit done);
        wr_t w;
        upg_wen_i  = 1'b1;
        upg_adr_i  = adr;
        upg_dat_i  = dat;
        upg_done_i = done;
        w.dmem = adr[14];
        w.adr  = adr[13:0];
        w.dat  = dat;
        w.due  = cyc + 1;
        exp_q.push_back(w);
        if (adr[14]) m_dcnt = (m_dcnt == 65535) ? 65535 : m_dcnt + 1;
        else         m_icnt = (m_icnt == 65535) ? 65535 : m_icnt + 1;
        tick();
        upg_wen_i  = 1'b0;
        upg_done_i = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output int n);
        n = 0;
        while (state_o !== s && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic arm;
        int n;
        start_pg = 1'b1;
        wait_state(S_ARM, 1000, n);
        check("debounce_cycles", n, DEB);
        m_icnt = 0;
        m_dcnt = 0;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_imem_cnt"}, {16'd0, imem_cnt_o}, m_icnt);
        check({tag, "_dmem_cnt"}, {16'd0, dmem_cnt_o}, m_dcnt);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [14:0] a;
        reset = 1'b1; start_pg = 1'b0; upg_wen_i = 1'b0; upg_done_i = 1'b0;
        upg_adr_i = '0; upg_dat_i = '0;
        m_icnt = 0; m_dcnt = 0;

        // Reset for 3 cycles, cpu_rst held one extra cycle afterwards.
        repeat (3) tick();
        check("rst_state", state_o, S_RUN);
        check("rst_cpu_rst", cpu_rst_o, 1);
        check("rst_upg_rst", upg_rst_o, 1);
        check("rst_err", err_o, 0);
        check("rst_wen", {imem_wen_o, dmem_wen_o}, 0);
        check("rst_adr", mem_adr_o, 0);
        check("rst_dat", mem_dat_o, 0);
        check_cnts("rst");
        reset = 1'b0;
        tick();
        check("cpu_rst_extra_cycle", cpu_rst_o, 1);
        tick();
        check("cpu_rst_released", cpu_rst_o, 0);
        check("run_state", state_o, S_RUN);
        check("run_upg_rst", upg_rst_o, 1);

        // Short press is rejected, full press arms.
        start_pg = 1'b1;
        repeat (DEB - 2) tick();
        start_pg = 1'b0;
        tick();
        check("short_press_run", state_o, S_RUN);
        arm();
        check("arm_state", state_o, S_ARM);
        check("arm_cpu_rst", cpu_rst_o, 1);
        check("arm_upg_rst", upg_rst_o, 0);

        // Directed imem/dmem writes, then random traffic.
        send(15'h0004, 32'h2408_0001, 1'b0);
        check("load_state", state_o, S_LOAD);
        send(15'h4010, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("first_imem_cnt", imem_cnt_o, 1);
        check("first_dmem_cnt", dmem_cnt_o, 1);
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            a = 15'($urandom);
            send(a, $urandom, 1'b0);
        end
        tick();
        check_cnts("random");

        // Write and done together: write forwarded, then FLUSH for FLUSH_CYC cycles.
        a = 15'($urandom);
        send(a, $urandom, 1'b1);
        check("flush_state", state_o, S_FLUSH);
        check("flush_cpu_rst", cpu_rst_o, 1);
        check("flush_upg_rst", upg_rst_o, 1);
        wait_state(S_RUN, 200, n);
        check("flush_cycles", n, FLC);
        check("run_cpu_rst_after_flush", cpu_rst_o, 0);
        check_cnts("after_done");
        repeat (2 * DEB) tick();
        check("held_button_no_rearm", state_o, S_RUN);
        start_pg = 1'b0;
        tick();

        // Timeout abort sets err, next arm clears it.
        arm();
        check("arm_err_clear", err_o, 0);
        send(15'h0100, $urandom, 1'b0);
        wait_state(S_FLUSH, 300, n);
        check("timeout_cycles", n, TMO);
        check("timeout_err", err_o, 1);
        wait_state(S_RUN, 200, n);
        check("timeout_flush_cycles", n, FLC);
        check("err_sticky_in_run", err_o, 1);
        start_pg = 1'b0;
        tick();
        arm();
        check("rearm_err_clear", err_o, 0);
        check_cnts("rearm");

        // Empty image: done straight from ARM.
        upg_done_i = 1'b1;
        tick();
        upg_done_i = 1'b0;
        check("empty_image_flush", state_o, S_FLUSH);
        wait_state(S_RUN, 200, n);
        check("empty_flush_cycles", n, FLC);
        start_pg = 1'b0;
        tick();

        // Saturation of the dmem counter with back-to-back writes.
        arm();
        for (int i = 0; i < 65540; i++) begin
            a = 15'($urandom);
            a[14] = 1'b1;
            send(a, $urandom, 1'b0);
        end
        send(15'h0002, $urandom, 1'b1);
        check_cnts("saturate");
        wait_state(S_RUN, 200, n);
        check("sat_flush_cycles", n, FLC);
        start_pg = 1'b0;
        tick();

        // Reset mid-LOAD, then writes in RUN are ignored.
        arm();
        for (int i = 0; i < 5; i++) begin
            a = 15'($urandom);
            send(a, $urandom, 1'b0);
        end
        tick();
        reset = 1'b1;
        start_pg = 1'b0;
        tick();
        m_icnt = 0;
        m_dcnt = 0;
        check("midload_rst_state", state_o, S_RUN);
        check("midload_rst_wen", {imem_wen_o, dmem_wen_o}, 0);
        check("midload_rst_cpu_rst", cpu_rst_o, 1);
        check_cnts("midload_rst");
        reset = 1'b0;
        upg_wen_i = 1'b1;
        upg_adr_i = 15'($urandom);
        repeat (3) tick();
        upg_wen_i = 1'b0;
        tick();
        check("run_ignores_wen_state", state_o, S_RUN);
        check("run_ignores_wen_out", {imem_wen_o, dmem_wen_o}, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
